// File: rtl/seq_mul_pkg.sv
`default_nettype none
// =============================================================================
// Module   : seq_mul_pkg
// Brief    : Shared state encoding and sizing helper for seq_shift_add_multiplier.
// Revision : 1.0 - initial release
// =============================================================================
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// =============================================================================
// Module   : ripple_carry_adder
// Brief    : WIDTH-bit unsigned ripple-carry adder with carry in/out.
// Revision : 1.0 - initial release
// =============================================================================
module ripple_carry_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
            assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = w_carry[WIDTH];

endmodule
`default_nettype wire

// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// =============================================================================
// Module   : seq_shift_add_multiplier
// Brief    : Iterative unsigned shift-add multiplier, valid/ready on both sides.
//            Optional macro SEQ_MUL_ZERO_SKIP_EN bypasses RUN for zero operands.
// Revision : 1.0 - initial release
// =============================================================================
module seq_shift_add_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;

    logic               w_idle;
    logic               w_accept;
    logic               w_consume;
    logic               w_last_step;
    logic [WIDTH-1:0]   w_add_b;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;

`ifdef SEQ_MUL_ZERO_SKIP_EN
    logic               w_zero_op;
    assign w_zero_op = (a == '0) || (b == '0);
`endif

    // The unused 2'd3 encoding behaves exactly like IDLE.
    assign w_idle      = !((r_state == RUN) || (r_state == DONE));
    assign in_ready    = w_idle && rst_n;
    assign w_accept    = in_valid && in_ready;
    assign w_consume   = r_out_valid && out_ready;
    assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));

    assign w_add_b = r_acc_lo[0] ? r_mcand : '0;

    ripple_carry_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (r_acc_hi),
        .b    (w_add_b),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN: begin
                if (w_last_step) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (w_consume) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
                if (w_accept) begin
`ifdef SEQ_MUL_ZERO_SKIP_EN
                    w_next_state = w_zero_op ? DONE : RUN;
`else
                    w_next_state = RUN;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The adder carry lands in the top bit after the shift, so nothing overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand     <= '0;
            r_acc_hi    <= '0;
            r_acc_lo    <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    {r_acc_hi, r_acc_lo} <= {w_cout, w_sum, r_acc_lo[WIDTH-1:1]};
                    r_cnt                <= r_cnt + 1'b1;
                end
                DONE: begin
                end
                default: begin
                    if (w_accept) begin
                        r_mcand  <= a;
                        r_acc_hi <= '0;
                        r_cnt    <= '0;
`ifdef SEQ_MUL_ZERO_SKIP_EN
                        r_acc_lo <= w_zero_op ? '0 : b;
`else
                        r_acc_lo <= b;
`endif
                    end
                end
            endcase
            r_out_valid <= (r_state == DONE) && !w_consume;
        end
    end

    assign out_valid = r_out_valid;
    assign product   = {r_acc_hi, r_acc_lo};

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// Module   : tb_seq_shift_add_multiplier
// Brief    : Self-checking bench: directed and random WIDTH=16 ops, exhaustive WIDTH=4.
// Revision : 1.0 - initial release
// =============================================================================
module tb_seq_shift_add_multiplier;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;

    logic        in_valid4;
    logic        in_ready4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        out_valid4;
    logic        out_ready4;
    logic [7:0]  product4;

    int          n_checks;
    int          n_pass;
    logic [7:0]  exp_q[$];

    seq_shift_add_multiplier #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .product   (product4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_latency(input logic [15:0] x, input logic [15:0] y);
`ifdef SEQ_MUL_ZERO_SKIP_EN
        if (x == 16'd0 || y == 16'd0) return 1;
`endif
        return 17;
    endfunction

    // One complete WIDTH=16 operation; hold = cycles of out_ready low once valid.
    task automatic run16(input logic [15:0] x, input logic [15:0] y, input int hold);
        logic [31:0] exp_p;
        int          k;
        exp_p = 32'(x) * 32'(y);
        @(negedge clk);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        chk_val("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        k        = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk_val("latency", 64'(k), 64'(exp_latency(x, y)));
        chk_val("product", 64'(product), 64'(exp_p));
        chk_val("in_ready_busy", 64'(in_ready), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk_val("hold_valid", 64'(out_valid), 64'd1);
            chk_val("hold_product", 64'(product), 64'(exp_p));
            chk_val("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_val("valid_drop", 64'(out_valid), 64'd0);
        chk_val("in_ready_back", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        out_ready  = 1'b0;
        in_valid4  = 1'b0;
        a4         = '0;
        b4         = '0;
        out_ready4 = 1'b0;

        #12;
        chk_val("rst_in_ready", 64'(in_ready), 64'd0);
        chk_val("rst_out_valid", 64'(out_valid), 64'd0);
        chk_val("rst_product", 64'(product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_val("post_rst_in_ready", 64'(in_ready), 64'd1);

        run16(16'd3, 16'd5, 0);
        run16(16'hFFFF, 16'hFFFF, 0);
        run16(16'h8000, 16'h0002, 0);
        run16(16'h0007, 16'h0009, 10);
        run16(16'h0000, 16'hABCD, 0);
        run16(16'hABCD, 16'h0000, 1);

        // Abort an in-flight operation with an asynchronous reset.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'h1234;
        b        = 16'h5678;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_val("abort_in_ready", 64'(in_ready), 64'd0);
        chk_val("abort_out_valid", 64'(out_valid), 64'd0);
        chk_val("abort_product", 64'(product), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_val("abort_no_stale", 64'(out_valid), 64'd0);
        run16(16'd2, 16'd9, 0);

        for (int r = 0; r < 16; r++) begin
            logic [15:0] x;
            logic [15:0] y;
            case ($urandom_range(0, 3))
                0:       x = 16'h0000;
                1:       x = 16'hFFFF;
                default: x = 16'($urandom);
            endcase
            y = (r % 5 == 4) ? 16'hFFFF : 16'($urandom);
            run16(x, y, $urandom_range(0, 3));
        end

        // WIDTH=4: every operand pair, random gaps on both handshakes, in order.
        fork
            begin
                @(negedge clk);
                for (int i = 0; i < 256; i++) begin
                    int tries;
                    in_valid4 = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    a4        = 4'(i >> 4);
                    b4        = 4'(i & 15);
                    in_valid4 = 1'b1;
                    tries     = 0;
                    while (!in_ready4 && tries < 60) begin
                        @(negedge clk);
                        tries++;
                    end
                    if (in_ready4) begin
                        exp_q.push_back(8'((i >> 4) * (i & 15)));
                    end else begin
                        chk_val("w4_accept_timeout", 64'(tries), 64'd0);
                    end
                    @(negedge clk);
                end
                in_valid4 = 1'b0;
            end
            begin
                int got;
                int cyc;
                logic [7:0] e;
                got = 0;
                cyc = 0;
                while (got < 256 && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready4 = 1'($urandom_range(0, 1));
                    if (out_valid4 && out_ready4) begin
                        if (exp_q.size() == 0) begin
                            chk_val("w4_spurious", 64'(product4), 64'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            chk_val("w4_product", 64'(product4), 64'(e));
                        end
                        got++;
                    end
                end
                if (got < 256) chk_val("w4_result_timeout", 64'(got), 64'd256);
                out_ready4 = 1'b0;
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
